// File: rtl/fetch_seq.sv
// Program-counter sequencer for the EV22 fetch stage: stall, prioritised
// ret/call/jump control and an internal return-address stack with sticky errors.
module fetch_seq #(
  parameter int             AW          = 11,
  parameter int             STACK_DEPTH = 4,
  parameter logic [AW-1:0]  RESET_VEC   = '0,
  localparam int            SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           stall,
  input  logic           jump,
  input  logic           call,
  input  logic           ret,
  input  logic [AW-1:0]  target,
  input  logic           clr_err,
  output logic [AW-1:0]  pc,
  output logic [SPW-1:0] sp,
  output logic           stack_full,
  output logic           stack_empty,
  output logic           err_ovf,
  output logic           err_unf
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef struct packed {
    logic ret;
    logic call;
    logic jump;
  } cmd_t;

  logic [AW-1:0]  stack [STACK_DEPTH];
  logic [AW-1:0]  pc_inc;
  logic [SPW-1:0] sp_dec;
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  wr_idx;
  cmd_t           cmd;
  logic           push;

  assign cmd         = '{ret: ret, call: call, jump: jump};
  assign pc_inc      = pc + AW'(1);
  assign sp_dec      = sp - SPW'(1);
  assign rd_idx      = sp_dec[IW-1:0];
  assign wr_idx      = sp[IW-1:0];
  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  // A push happens only for a call that is not overridden by stall or ret.
  assign push = !stall && !cmd.ret && cmd.call && !stack_full;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc      <= RESET_VEC;
      sp      <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      // Clear first so a same-cycle new error below takes precedence.
      if (clr_err) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end
      if (!stall) begin
        if (cmd.ret) begin
          if (!stack_empty) begin
            pc <= stack[rd_idx];
            sp <= sp_dec;
          end else begin
            pc      <= pc_inc;
            err_unf <= 1'b1;
          end
        end else if (cmd.call) begin
          pc <= target;
          if (!stack_full) sp <= sp + SPW'(1);
          else             err_ovf <= 1'b1;
        end else if (cmd.jump) begin
          pc <= target;
        end else begin
          pc <= pc_inc;
        end
      end
    end
  end

  // Stack storage carries no reset; entries above sp are don't-care.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: driver pushes model predictions, monitor
// pops and compares one prediction per clock edge.
module tb_fetch_seq;

  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << AW) - 1;
  localparam logic [AW-1:0] RVEC = '0;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           stall = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, clr_err = 1'b0;
  logic [AW-1:0]  target = '0;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic           stack_full, stack_empty, err_ovf, err_unf;

  fetch_seq #(.AW(AW), .STACK_DEPTH(DEPTH), .RESET_VEC(RVEC)) dut (
    .clk(clk), .nreset(nreset), .stall(stall), .jump(jump), .call(call),
    .ret(ret), .target(target), .clr_err(clr_err), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    pc;
    int    sp;
    bit    full;
    bit    empty;
    bit    ovf;
    bit    unf;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int   m_pc;
  int   m_stk[$];
  bit   m_ovf, m_unf;

  function automatic exp_t snap(input string tag);
    exp_t e;
    e.pc    = m_pc;
    e.sp    = m_stk.size();
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.tag   = tag;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    checks++;
    if (int'(pc) !== e.pc || int'(sp) !== e.sp || stack_full !== e.full ||
        stack_empty !== e.empty || err_ovf !== e.ovf || err_unf !== e.unf) begin
      errors++;
      $display("FAIL %s: got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
               e.tag, pc, sp, stack_full, stack_empty, err_ovf, err_unf,
               e.pc[AW-1:0], e.sp, e.full, e.empty, e.ovf, e.unf);
    end
  endtask

  function automatic void model_reset();
    m_pc  = int'(RVEC);
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(input bit st, jp, cl, rt, input int tg, input bit clr);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (st) return;
    if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc  = (m_pc + 1) & MASK;
        m_unf = 1'b1;
      end
    end else if (cl) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) & MASK);
      else m_ovf = 1'b1;
      m_pc = tg & MASK;
    end else if (jp) begin
      m_pc = tg & MASK;
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
  endfunction

  task automatic cyc(input bit st, jp, cl, rt, input int tg, input bit clr, input string tag);
    @(negedge clk);
    stall = st; jump = jp; call = cl; ret = rt; target = AW'(tg); clr_err = clr;
    model_step(st, jp, cl, rt, tg, clr);
    exp_q.push_back(snap(tag));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, tag);
  endtask

  // Assert reset between edges, check immediately, release just after a posedge.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    stall = 0; jump = 0; call = 0; ret = 0; clr_err = 0;
    nreset = 1'b0;
    model_reset();
    #1 compare(snap({tag, "_async"}));
    @(posedge clk); #2;
    nreset = 1'b1;
    #1 compare(snap({tag, "_release"}));
  endtask

  // Monitor: one prediction is consumed per active edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (nreset && exp_q.size() > 0) compare(exp_q.pop_front());
  end

  initial begin
    model_reset();
    // 1: reset then count
    #1 compare(snap("reset_state"));
    @(posedge clk); #2 nreset = 1'b1;
    idle(5, "t1_count");

    // 2: single call/ret
    do_reset("t2_rst");
    idle(3, "t2_to3");
    cyc(0, 0, 1, 0, 'h100, 0, "t2_call");
    idle(2, "t2_body");
    cyc(0, 0, 0, 1, 0, 0, "t2_ret");

    // 3: overflow then underflow
    do_reset("t3_rst");
    cyc(0, 0, 1, 0, 'h10, 0, "t3_call1");
    cyc(0, 0, 1, 0, 'h20, 0, "t3_call2");
    cyc(0, 0, 1, 0, 'h30, 0, "t3_call3");
    cyc(0, 0, 1, 0, 'h40, 0, "t3_call4");
    cyc(0, 0, 1, 0, 'h50, 0, "t3_call5_ovf");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, "t3_ret");
    cyc(0, 0, 0, 1, 0, 0, "t3_ret5_unf");

    // 4: priority and stall with flags still set from above
    cyc(0, 0, 1, 0, 'h200, 0, "t4_call");
    cyc(0, 1, 1, 1, 'h333, 0, "t4_all_cmds");
    cyc(0, 0, 1, 0, 'h250, 0, "t4_call2");
    cyc(1, 1, 0, 0, 'h444, 0, "t4_stall1");
    cyc(1, 1, 0, 0, 'h444, 1, "t4_stall_clr");
    cyc(1, 1, 0, 0, 'h444, 0, "t4_stall3");
    cyc(0, 0, 0, 1, 0, 1, "t4_ret_clr");

    // 5: wraparound
    cyc(0, 1, 0, 0, 'h7FF, 0, "t5_jmp");
    cyc(0, 0, 0, 0, 0, 0, "t5_wrap");
    cyc(0, 1, 0, 0, 'h7FF, 0, "t5_jmp2");
    cyc(0, 0, 1, 0, 'h123, 0, "t5_call_wrap");
    cyc(0, 0, 0, 0, 0, 0, "t5_idle");
    cyc(0, 0, 0, 1, 0, 0, "t5_ret_wrap");

    // clr_err coincident with a new error: new error wins
    cyc(0, 0, 0, 1, 0, 1, "t5_unf_clr");

    // random phase
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
          ($urandom % 5) == 0, int'($urandom) & MASK, ($urandom % 10) == 0, "rand");

    // 6: async reset with sp=2 and err_ovf=1
    cyc(0, 0, 0, 0, 0, 1, "t6_clr");
    while (m_stk.size() > 0) cyc(0, 0, 0, 1, 0, 0, "t6_drain");
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 'h60 + i, 0, "t6_fill");
    cyc(0, 0, 0, 1, 0, 0, "t6_pop1");
    cyc(0, 0, 0, 1, 0, 0, "t6_pop2");
    do_reset("t6_rst");
    idle(3, "t6_resume");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions unconsumed, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Parametrised program-counter sequencer for the EV22 core. It replaces the single-condition PC register with a generalised version that adds:
- configurable address width and reset vector;
- a pipeline stall input;
- prioritised jump, call and return control;
- an internal return-address stack with overflow/underflow detection.

It sits between the decode/branch-condition logic and the instruction ROM address input.

Parameters:
AW, 11, PC/address width in bits
STACK_DEPTH, 4, return-address stack entries (>=1)
RESET_VEC, 0, PC value loaded on reset (AW bits)

Ports:
clk  input  1  rising-edge clock
nreset  input  1  asynchronous, active-low reset
stall  input  1  hold PC, stack and flags this cycle
jump  input  1  load PC from target (condition already resolved upstream)
call  input  1  push PC+1, load PC from target
ret  input  1  pop stack into PC
target  input  AW  jump/call destination
clr_err  input  1  clear sticky error flags
pc  output  AW  current fetch address (registered)
sp  output  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH
stack_full  output  1  sp == STACK_DEPTH (combinational from sp)
stack_empty  output  1  sp == 0 (combinational from sp)
err_ovf  output  1  sticky: call issued while full
err_unf  output  1  sticky: ret issued while empty

Behaviour:
Reset (nreset low, asynchronous, any time including mid-operation):
- pc = RESET_VEC, sp = 0, err_ovf = 0, err_unf = 0.
- Stack contents are don't-care.

Update timing:
- All state updates on posedge clk. The pc change is visible the cycle after the command is sampled (1-cycle latency).

Per-cycle priority (highest first):
1. stall=1: pc, sp and stack hold. err flags hold, except that clr_err still clears them.
2. ret=1:
   - If sp>0: pc <= stack[sp-1], sp <= sp-1.
   - If sp==0: pc <= pc+1, sp stays 0, err_unf <= 1.
3. call=1:
   - If sp<STACK_DEPTH: stack[sp] <= pc+1, sp <= sp+1, pc <= target.
   - If full: pc <= target, no push, sp unchanged, err_ovf <= 1.
4. jump=1: pc <= target.
5. Otherwise: pc <= pc+1.

Simultaneous commands:
- When several of jump/call/ret are high, only the highest-priority one acts. Lower ones are ignored; no error is raised for the ignored ones.

Arithmetic:
- pc+1 is modulo 2^AW. All-ones wraps to 0, including the return address pushed by call.

Error flags:
- err_ovf/err_unf stay set until clr_err=1 or reset.
- clr_err clears both flags on the next edge.
- If clr_err and a new error occur in the same cycle, the new error wins (flag = 1).

Stack:
- LIFO. Entries above sp are not modified by ret.

Outputs:
- pc and sp are registers with no combinational path from the inputs.

Test Plan:
1. Reset, then 5 idle cycles, RESET_VEC=0 -> pc sequence 0,1,2,3,4,5; sp=0; stack_empty=1.
2. At pc=3 assert call, target=0x100 for one cycle; 2 idle cycles; then ret -> pc 0x100, 0x101, 0x102, then 0x004; sp goes 1 then 0; no error flags.
3. STACK_DEPTH=4: five nested calls, targets 0x10, 0x20, 0x30, 0x40, 0x50 ->
   - the 5th call gives pc=0x50, sp stays 4, err_ovf=1;
   - four rets then return to the addresses pushed by calls 4, 3, 2, 1 (call-site pc + 1);
   - a 5th ret sets err_unf=1 and gives pc+1.
4. call=1, ret=1, jump=1 asserted together with sp=1 -> ret wins: pc = popped value, sp=0, no push. stall=1 held 3 cycles with jump=1 -> pc and sp frozen; clr_err during stall clears the flags.
5. AW=11, pc=0x7FF, idle -> pc=0x000. call at pc=0x7FF -> pushed return address 0x000; the later ret restores pc=0x000.
6. Assert nreset low asynchronously between clock edges while sp=2 and err_ovf=1 -> pc=RESET_VEC, sp=0, flags=0 immediately. After release, counting resumes from RESET_VEC on the next edge.
